// File: rtl/mdu_pkg.sv
// Shared MDU definitions: multiplier FSM states, signedness encodings and iteration counts.
package mdu_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StBusy = 2'b01,
      StDone = 2'b10
   } mul_state_e;

   localparam logic [1:0] MUL_SS = 2'b11;
   localparam logic [1:0] MUL_SU = 2'b10;
   localparam logic [1:0] MUL_UU = 2'b00;

   // MULW works on 34-bit extended operands: two bits per step.
   localparam int unsigned ITER_W = 17;

   function automatic int unsigned mul_iter(input int unsigned xlen);
      return (xlen + 2) / 2;
   endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth partial-product selector: decodes a 3-bit multiplier window into
// a (possibly inverted) multiple of the multiplicand plus its two's-complement carry-in.
module booth_pp_sel #(
   parameter int unsigned W = 132
) (
   input  logic [2:0]   code_i,
   input  logic [W-1:0] x_i,
   output logic [W-1:0] pp_o,
   output logic         cin_o
);

   logic         neg;
   logic         zero;
   logic         one;
   logic         two;
   logic [W-1:0] mag;

   always_comb begin
      neg  = code_i[2];
      zero = (code_i == 3'b000) || (code_i == 3'b111);
      two  = (code_i == 3'b011) || (code_i == 3'b100);
      one  = !zero && !two;

      mag = '0;
      if (one) begin
         mag = x_i;
      end else if (two) begin
         mag = {x_i[W-2:0], 1'b0};
      end

      // Negation is ~mag + 1; the +1 rides into the accumulator as carry-in.
      pp_o  = neg ? ~mag : mag;
      cin_o = neg;
   end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier for RV64 MUL/MULH/MULHSU/MULHU/MULW.
// Two multiplier bits retire per cycle; results are held until the consumer takes them.
module booth_mul_seq
   import mdu_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mul_valid,
   output logic            mul_ready,
   input  logic            flush,
   input  logic            mulw,
   input  logic [1:0]      mul_signed,
   input  logic [XLEN-1:0] multiplicand,
   input  logic [XLEN-1:0] multiplier,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result_hi,
   output logic [XLEN-1:0] result_lo
);

   localparam int unsigned EW   = XLEN + 2;
   localparam int unsigned YW   = XLEN + 3;
   localparam int unsigned PW   = 2 * XLEN + 4;
   localparam int unsigned ITER = mul_iter(XLEN);
   localparam int unsigned CntW = $clog2(ITER + 1);

   mul_state_e      state_q;
   logic            ready_q;
   logic            valid_q;
   logic            mulw_q;
   logic [CntW-1:0] cnt_q;
   logic [PW-1:0]   x_q;
   logic [PW-1:0]   x_d;
   logic [YW-1:0]   y_q;
   logic [YW-1:0]   y_d;
   logic [PW-1:0]   p_q;
   logic [PW-1:0]   p_d;
   logic [XLEN-1:0] hi_q;
   logic [XLEN-1:0] hi_d;
   logic [XLEN-1:0] lo_q;
   logic [XLEN-1:0] lo_d;

   logic [EW-1:0]   x_ext;
   logic [EW-1:0]   y_ext;
   logic [PW-1:0]   pp;
   logic            pp_cin;
   logic            unused_p_top;

   always_comb begin
      if (mulw) begin
         x_ext = {{(EW-32){multiplicand[31]}}, multiplicand[31:0]};
         y_ext = {{(EW-32){multiplier[31]}}, multiplier[31:0]};
      end else begin
         x_ext = {{2{mul_signed[1] & multiplicand[XLEN-1]}}, multiplicand};
         y_ext = {{2{mul_signed[0] & multiplier[XLEN-1]}}, multiplier};
      end
   end

   booth_pp_sel #(
      .W (PW)
   ) u_pp_sel (
      .code_i (y_q[2:0]),
      .x_i    (x_q),
      .pp_o   (pp),
      .cin_o  (pp_cin)
   );

   always_comb begin
      p_d = p_q + pp + {{(PW-1){1'b0}}, pp_cin};
      x_d = {x_q[PW-3:0], 2'b00};
      y_d = {{2{y_q[YW-1]}}, y_q[YW-1:2]};
      // MULW returns the sign-extended 32-bit product in both halves.
      if (mulw_q) begin
         lo_d = {{(XLEN-32){p_d[31]}}, p_d[31:0]};
         hi_d = lo_d;
      end else begin
         lo_d = p_d[XLEN-1:0];
         hi_d = p_d[2*XLEN-1:XLEN];
      end
   end

   assign unused_p_top = ^p_d[PW-1:2*XLEN];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         mulw_q  <= 1'b0;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         p_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else if (flush) begin
         state_q <= StIdle;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (mul_valid) begin
                  state_q <= StBusy;
                  ready_q <= 1'b0;
                  mulw_q  <= mulw;
                  cnt_q   <= mulw ? CntW'(ITER_W) : CntW'(ITER);
                  x_q     <= {{(PW-EW){x_ext[EW-1]}}, x_ext};
                  y_q     <= {y_ext, 1'b0};
                  p_q     <= '0;
               end
            end
            StBusy: begin
               x_q   <= x_d;
               y_q   <= y_d;
               p_q   <= p_d;
               cnt_q <= cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) begin
                  state_q <= StDone;
                  valid_q <= 1'b1;
                  hi_q    <= hi_d;
                  lo_q    <= lo_d;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_q <= StIdle;
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               valid_q <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign mul_ready = ready_q;
   assign out_valid = valid_q;
   assign result_hi = hi_q;
   assign result_lo = lo_q;

endmodule
